div_32: RTL



---
 rtl/div_32.sv | 134 +++++++++++++
 1 files changed

// File: rtl/div_32.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock,
// registered quotient/remainder and a one-cycle done pulse.
module div_32 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N:0]    p_q, p_d;
  logic [N-1:0]  w_q, w_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    shifted;
  logic [N:0]    trial;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      w_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      w_q     <= w_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (B == '0) ? DONE : RUN;
      RUN:  if (cnt_q == CW'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Shift {P, W} left, then try to subtract the divisor from the new P.
  assign shifted = {p_q[N-1:0], w_q[N-1]};
  assign trial   = shifted - {1'b0, d_q};

  always_comb begin
    p_d   = p_q;
    w_d   = w_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (B == '0) begin
            q_d   = '1;
            r_d   = A;
            dbz_d = 1'b1;
          end else begin
            w_d   = A;
            p_d   = '0;
            d_d   = B;
            cnt_d = CW'(N);
          end
        end
      end
      RUN: begin
        if (!trial[N]) begin
          p_d = trial;
          w_d = {w_q[N-2:0], 1'b1};
        end else begin
          p_d = shifted;
          w_d = {w_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d   = w_d;
          r_d   = p_d[N-1:0];
          dbz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule
